// File: rtl/sys_probe_scanner_if.sv
// Observation/stream bundle for sys_probe_scanner: select/leds probe pair toward `system`
// plus the valid/ready capture stream toward the host logger.
interface sys_probe_scanner_if;
   logic [7:0]  SYS_output_sel;
   logic [26:0] SYS_leds;
   logic [31:0] PRB_data;
   logic        PRB_valid;
   logic        PRB_ready;

   modport master (
      output SYS_output_sel,
      output PRB_data,
      output PRB_valid,
      input  SYS_leds,
      input  PRB_ready
   );

   modport slave (
      input  SYS_output_sel,
      input  PRB_data,
      input  PRB_valid,
      output SYS_leds,
      output PRB_ready
   );
endinterface

// File: rtl/sys_probe_scanner.sv
// Debug capture engine: sweeps SYS_output_sel, waits SETTLE cycles per code, snapshots
// SYS_leds into a back-pressured 32-bit stream word {sel[4:0], leds[26:0]}.
module sys_probe_scanner #(
   parameter int NUM_SEL = 8,
   parameter int SETTLE  = 2
) (
   input  logic SYS_clk,
   input  logic SYS_reset,
   input  logic PRB_start,
   input  logic PRB_continuous,
   input  logic PRB_abort,
   output logic PRB_busy,
   output logic PRB_done,
   sys_probe_scanner_if.master bus
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SEND
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [4:0]         r_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_data;
   logic               r_done;
   logic               w_settled;
   logic               w_lastSel;
   logic               w_accept;
   logic               w_busy;
   logic               w_valid;

   assign w_settled = (r_cnt == CNT_W'(SETTLE - 1));
   assign w_lastSel = (r_sel == 5'(NUM_SEL - 1));
   assign w_accept  = (r_state == S_SEND) && bus.PRB_ready;

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (PRB_start) w_next = S_SETTLE;
         S_SETTLE: if (w_settled) w_next = S_SEND;
         S_SEND: begin
            if (w_accept) begin
               if (w_lastSel && !PRB_continuous) w_next = S_IDLE;
               else                              w_next = S_SETTLE;
            end
         end
         default:  w_next = S_IDLE;
      endcase
      // Abort outranks both start and accept.
      if (PRB_abort) w_next = S_IDLE;
   end

   always_comb begin
      w_busy  = (r_state != S_IDLE);
      w_valid = (r_state == S_SEND);
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         r_sel  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (PRB_abort) begin
            r_sel <= '0;
            r_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (PRB_start) begin
                     r_sel <= '0;
                     r_cnt <= '0;
                  end
               end
               S_SETTLE: begin
                  if (w_settled) begin
                     r_data <= {r_sel, bus.SYS_leds};
                     r_cnt  <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_SEND: begin
                  if (w_accept) begin
                     r_cnt <= '0;
                     if (w_lastSel) begin
                        r_sel  <= '0;
                        r_done <= 1'b1;
                     end else begin
                        r_sel <= r_sel + 1'b1;
                     end
                  end
               end
               default: begin
                  r_sel <= '0;
                  r_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bus.SYS_output_sel = {3'b000, r_sel};
   assign bus.PRB_data       = r_data;
   assign bus.PRB_valid      = w_valid;
   assign PRB_busy           = w_busy;
   assign PRB_done           = r_done;

endmodule

// File: tb/tb_sys_probe_scanner.sv
// Self-checking bench for sys_probe_scanner: timing table for a plain sweep, scoreboard of
// expected stream words, and hand sequences for stall, continuous, abort and mid-sweep reset.
module tb_sys_probe_scanner;
   localparam int NUM_SEL = 8;
   localparam int SETTLE  = 2;

   typedef struct {
      int         edgeNo;
      logic [7:0] sel;
      logic       valid;
      logic       busy;
      logic       done;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        continuous;
   logic        abort;
   logic        busy;
   logic        done;
   logic        ledsToggle = 1'b0;
   logic [26:0] toggleVal = 27'h2A5A5A5;
   int          checks = 0;
   int          errors = 0;
   int          edgeIdx = 0;
   logic [31:0] sbQueue[$];
   vec_t        vecs[10];

   sys_probe_scanner_if bus();

   sys_probe_scanner #(
      .NUM_SEL(NUM_SEL),
      .SETTLE (SETTLE)
   ) dut (
      .SYS_clk       (clk),
      .SYS_reset     (rst_n),
      .PRB_start     (start),
      .PRB_continuous(continuous),
      .PRB_abort     (abort),
      .PRB_busy      (busy),
      .PRB_done      (done),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) toggleVal <= ~toggleVal;

   // Model of `system`: leds follow the select combinationally unless forced to toggle.
   always_comb begin
      bus.SYS_leds = ledsToggle ? toggleVal : 27'(bus.SYS_output_sel) * 27'h111;
   end

   function automatic logic [31:0] wordOf(int i);
      logic [4:0] s;
      s = 5'(i);
      return {s, 27'(i * 'h111)};
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(logic st, logic rdy, logic cont, logic ab);
      start          = st;
      bus.PRB_ready  = rdy;
      continuous     = cont;
      abort          = ab;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edgeIdx++;
   endtask

   task automatic startSweep(logic cont, int sweeps);
      for (int s = 0; s < sweeps; s++)
         for (int i = 0; i < NUM_SEL; i++) sbQueue.push_back(wordOf(i));
      applyStimulus(1'b1, 1'b1, cont, 1'b0);
      @(posedge clk);
      #1;
      edgeIdx = 0;
      start   = 1'b0;
   endtask

   task automatic waitIdle(int maxCycles, string name);
      int n;
      n = 0;
      while (busy === 1'b1 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput(name, 32'(busy), 32'd0);
   endtask

   // Scoreboard consumer: an accept happens at the next rising edge when valid & ready and no abort.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.PRB_valid === 1'b1 && bus.PRB_ready === 1'b1 && abort === 1'b0) begin
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected word: got 0x%0h, expected no word", bus.PRB_data);
         end else begin
            checkOutput($sformatf("word sel=%0d", bus.SYS_output_sel), bus.PRB_data, sbQueue.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneCnt;
      int busyDrops;
      int stray;

      vecs[0] = '{0,  8'd0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1,  8'd0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{2,  8'd0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{3,  8'd1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{5,  8'd1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{11, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{14, 8'd4, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{23, 8'd7, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{24, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{25, 8'd0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      #12;
      checkOutput("reset sel",   32'(bus.SYS_output_sel), 32'd0);
      checkOutput("reset data",  bus.PRB_data,            32'd0);
      checkOutput("reset valid", 32'(bus.PRB_valid),      32'd0);
      checkOutput("reset busy",  32'(busy),               32'd0);
      checkOutput("reset done",  32'(done),               32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("[TB] plain sweep");
      startSweep(1'b0, 1);
      for (int v = 0; v < 10; v++) begin
         while (edgeIdx < vecs[v].edgeNo) tick();
         checkOutput($sformatf("sweep e%0d sel", vecs[v].edgeNo),   32'(bus.SYS_output_sel), 32'(vecs[v].sel));
         checkOutput($sformatf("sweep e%0d valid", vecs[v].edgeNo), 32'(bus.PRB_valid),      32'(vecs[v].valid));
         checkOutput($sformatf("sweep e%0d busy", vecs[v].edgeNo),  32'(busy),               32'(vecs[v].busy));
         checkOutput($sformatf("sweep e%0d done", vecs[v].edgeNo),  32'(done),               32'(vecs[v].done));
      end
      checkOutput("sweep scoreboard empty", 32'(sbQueue.size()), 32'd0);

      $display("[TB] stall on word 3 with leds toggling");
      tick();
      startSweep(1'b0, 1);
      while (edgeIdx < 11) tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      ledsToggle = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("stall sel",   32'(bus.SYS_output_sel), 32'd3);
         checkOutput("stall data",  bus.PRB_data,            wordOf(3));
         checkOutput("stall valid", 32'(bus.PRB_valid),      32'd1);
      end
      ledsToggle = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("post-stall valid m", 32'(bus.PRB_valid),      32'd0);
      checkOutput("post-stall sel m",   32'(bus.SYS_output_sel), 32'd4);
      tick();
      checkOutput("post-stall valid m+1", 32'(bus.PRB_valid), 32'd0);
      tick();
      checkOutput("post-stall valid m+2", 32'(bus.PRB_valid), 32'd1);
      checkOutput("post-stall data m+2",  bus.PRB_data,       wordOf(4));
      waitIdle(60, "stall sweep completes");
      checkOutput("stall scoreboard empty", 32'(sbQueue.size()), 32'd0);

      $display("[TB] continuous sweeps");
      tick();
      doneCnt   = 0;
      busyDrops = 0;
      startSweep(1'b1, 3);
      while (edgeIdx < 71) begin
         tick();
         if (done === 1'b1) doneCnt++;
         if (busy !== 1'b1) busyDrops++;
         if (edgeIdx == 24) begin
            checkOutput("cont e24 done",  32'(done),               32'd1);
            checkOutput("cont e24 sel",   32'(bus.SYS_output_sel), 32'd0);
            checkOutput("cont e24 valid", 32'(bus.PRB_valid),      32'd0);
         end
         if (edgeIdx == 26) begin
            checkOutput("cont e26 valid", 32'(bus.PRB_valid),      32'd1);
            checkOutput("cont e26 sel",   32'(bus.SYS_output_sel), 32'd0);
         end
         if (edgeIdx == 50) continuous = 1'b0;
      end
      checkOutput("cont done pulses", 32'(doneCnt),   32'd2);
      checkOutput("cont busy drops",  32'(busyDrops), 32'd0);
      tick();
      checkOutput("cont final done", 32'(done), 32'd1);
      checkOutput("cont final busy", 32'(busy), 32'd0);
      tick();
      checkOutput("cont done width", 32'(done), 32'd0);
      checkOutput("cont scoreboard empty", 32'(sbQueue.size()), 32'd0);

      $display("[TB] abort during settle of sel 5");
      tick();
      startSweep(1'b0, 1);
      while (edgeIdx < 15) tick();
      checkOutput("pre-abort sel",   32'(bus.SYS_output_sel), 32'd5);
      checkOutput("pre-abort valid", 32'(bus.PRB_valid),      32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("abort busy",  32'(busy),               32'd0);
      checkOutput("abort valid", 32'(bus.PRB_valid),      32'd0);
      checkOutput("abort sel",   32'(bus.SYS_output_sel), 32'd0);
      checkOutput("abort done",  32'(done),               32'd0);
      checkOutput("abort data",  bus.PRB_data,            wordOf(4));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      sbQueue.delete();
      stray = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checkOutput("abort quiet", 32'(stray), 32'd0);

      $display("[TB] reset mid-sweep");
      startSweep(1'b0, 1);
      while (edgeIdx < 5) tick();
      checkOutput("pre-reset valid", 32'(bus.PRB_valid),      32'd1);
      checkOutput("pre-reset sel",   32'(bus.SYS_output_sel), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset sel",   32'(bus.SYS_output_sel), 32'd0);
      checkOutput("midreset data",  bus.PRB_data,            32'd0);
      checkOutput("midreset valid", 32'(bus.PRB_valid),      32'd0);
      checkOutput("midreset busy",  32'(busy),               32'd0);
      checkOutput("midreset done",  32'(done),               32'd0);
      sbQueue.delete();
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (busy !== 1'b0 || bus.PRB_valid !== 1'b0) stray++;
      end
      checkOutput("post-reset idle", 32'(stray), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
